rgb_shade_sequencer: RTL and testbench
======================================

Name: rgb_shade_sequencer

Overview:
- Shades one 24-bit RGB pixel by a scalar 8-bit light intensity, with an optional saturating ambient term.
- Sits directly upstream of the shared rgb_multiplication unit. It feeds that unit the R, G and B channels on consecutive cycles and consumes its 1-cycle-latency `valid`/`result` stream.
- Reassembles the shaded pixel and presents it on a valid/ready output toward the framebuffer writer.

Parameters:
- AMBIENT_EN, 1, when 1 add `in_ambient` to each shaded channel with saturation at 255; when 0 ambient is ignored.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input pixel valid.
- `in_ready` output 1: sequencer can accept a pixel.
- `in_color` input 24: R[23:16], G[15:8], B[7:0].
- `in_intensity` input 8: light intensity, 0x00..0xFF.
- `in_ambient` input 8: ambient offset per channel.
- `out_valid` output 1: shaded pixel valid.
- `out_ready` input 1: downstream accepts the pixel.
- `out_color` output 24: shaded pixel, same channel packing as `in_color`.
- `busy` output 1: high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, `out_valid`=0, `out_color`=0, issue and capture counters=0, `busy`=0. `in_ready`=1 after the first edge with `rst` low.
- Multiplier contract: an 8x8 product, upper 8 bits, registered. `result`/`valid` appear one edge after `start`.
- FSM states:
  - IDLE: `in_ready`=1. On edge with `in_valid`&&`in_ready`, latch color, intensity and ambient; go to ISSUE; issue index=0.
  - ISSUE: drive `start`=1, `a`=channel[issue index] (0=R, 1=G, 2=B), `b`=latched intensity. Index increments every cycle. After issuing B, go to DRAIN.
  - DRAIN: `start`=0. Wait for the B result.
  - OUT: `out_valid`=1. `out_color` holds stable until `out_ready`. On edge with `out_ready`, go to IDLE.
- Capture:
  - Whenever the multiplier's `valid`=1 in ISSUE or DRAIN, write the result into channel[capture index] and increment the index.
  - With AMBIENT_EN=1 the written value is min(255, result+ambient). This uses a 9-bit add, saturating on carry.
  - The capture of index 2 moves the FSM to OUT at the same edge.
- Latency: accept edge k → R issued in the cycle after k. `out_valid` is high after edge k+4.
- Throughput: at most one pixel per 6 cycles with `out_ready` tied high. `in_ready`=(state==IDLE) only; there is no overlap.
- Mid-transaction inputs: `in_color`, `in_intensity` and `in_ambient` changes after acceptance have no effect.
- Output stability: `out_color` is registered and does not change while `out_valid`&&!`out_ready`.
- Multiplier valid filtering: the multiplier has no reset. Its `valid` may be stale or X for one edge after reset. The sequencer ignores multiplier `valid` in IDLE and OUT, and drives `start`=0 during and after reset.
- Reset mid-operation: `rst` in any state aborts the pixel, discards partial captures, and returns to IDLE with `out_valid`=0. A multiplier `valid` arriving on the next edge is ignored.
- `out_ready` held low: remain in OUT indefinitely. `in_ready` stays 0 and no new pixel is accepted.

Decomposition:
- Shared package (Types/Parameters):
  - CH_W=8 and PIX_W=24.
  - Channel index typedef (2-bit, values R=0, G=1, B=2).
  - Sequencer state enum {IDLE, ISSUE, DRAIN, OUT}.
- Sub-module: one instance of rgb_multiplication inside the sequencer. No other sub-modules; the saturating add is inline.

Test Plan:
- Basic shading: `in_color`=0x402010, intensity=0x80, AMBIENT_EN=1, ambient=0x00 → `out_color`=0x201008. `out_valid` rises 4 edges after accept.
- Near-full intensity: `in_color`=0xFF8000, intensity=0xFF, ambient=0x00 → `out_color`=0xFE7F00 (255·255>>8=254, 128·255>>8=127).
- Ambient saturation: `in_color`=0xFF8000, intensity=0xFF, ambient=0x10 → `out_color`=0xFF8F10. R saturates at 255. Repeat with AMBIENT_EN=0 → 0xFE7F00.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`. Require `out_color` stable, `in_ready`=0, and no second accept while `in_valid` is held high. Release `out_ready` → IDLE one edge later, next pixel accepted the edge after.
- Reset mid-op: assert `rst` for one cycle in ISSUE after the G issue. Require `out_valid`=0, state IDLE, and no capture on the following edge. A subsequent pixel 0x402010/0x80 still yields 0x201008.
- Back-to-back stream: 8 random pixels with `in_valid` and `out_ready` tied high. Output order and values must match a reference model of ((c·i)>>8)+amb saturating. Require 6 cycles between accepts.

Source files
------------

// File: rtl/rgb_shade_sequencer_pkg.sv
// rtl/rgb_shade_sequencer_pkg.sv - shared widths, channel index and state types
package rgb_shade_sequencer_pkg;

  localparam int CH_W   = 8;
  localparam int PIX_W  = 24;
  localparam int PROD_W = 2 * CH_W;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/rgb_multiplication.sv
// rtl/rgb_multiplication.sv - registered 8x8 multiply returning the upper product byte
module rgb_multiplication
  import rgb_shade_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            start,
  input  logic [CH_W-1:0] a,
  input  logic [CH_W-1:0] b,
  output logic            valid,
  output logic [CH_W-1:0] result
);

  // No reset here: the sequencer filters valid by its own state.
  always_ff @(posedge clk) begin
    valid  <= start;
    result <= CH_W'((PROD_W'(a) * PROD_W'(b)) >> CH_W);
  end

endmodule

// File: rtl/rgb_shade_sequencer.sv
// rtl/rgb_shade_sequencer.sv - issues R/G/B to the shared multiplier and reassembles the shaded pixel
module rgb_shade_sequencer
  import rgb_shade_sequencer_pkg::*;
#(
  parameter bit AMBIENT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_color,
  input  logic [CH_W-1:0]  in_intensity,
  input  logic [CH_W-1:0]  in_ambient,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_color,
  output logic             busy
);

  seq_state_t       r_state;
  seq_state_t       w_next;
  chan_idx_t        r_issue_idx;
  chan_idx_t        r_cap_idx;
  logic [PIX_W-1:0] r_color;
  logic [CH_W-1:0]  r_intensity;
  logic [CH_W-1:0]  r_ambient;
  logic [PIX_W-1:0] r_out_color;

  logic             w_issue;
  logic             w_cap;
  logic             w_mul_start;
  logic             w_mul_valid;
  logic [CH_W-1:0]  w_mul_a;
  logic [CH_W-1:0]  w_mul_result;
  logic [CH_W:0]    w_sum;
  logic [CH_W-1:0]  w_cap_val;

  assign w_mul_start = w_issue && !rst;

  rgb_multiplication u_mult (
    .clk    (clk),
    .start  (w_mul_start),
    .a      (w_mul_a),
    .b      (r_intensity),
    .valid  (w_mul_valid),
    .result (w_mul_result)
  );

  // Carry out of the 9-bit sum means the channel clips to full scale.
  assign w_sum     = {1'b0, w_mul_result} + {1'b0, r_ambient};
  assign w_cap_val = AMBIENT_EN ? (w_sum[CH_W] ? {CH_W{1'b1}} : w_sum[CH_W-1:0])
                                : w_mul_result;

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_mul_a = '0;
    w_cap   = w_mul_valid && ((r_state == ISSUE) || (r_state == DRAIN));
    case (r_issue_idx)
      CH_R:    w_mul_a = r_color[2*CH_W +: CH_W];
      CH_G:    w_mul_a = r_color[CH_W +: CH_W];
      default: w_mul_a = r_color[0 +: CH_W];
    endcase
    case (r_state)
      IDLE: begin
        if (in_valid) w_next = ISSUE;
      end
      ISSUE: begin
        w_issue = 1'b1;
        if (r_issue_idx == CH_B) w_next = DRAIN;
      end
      DRAIN: begin
        if (w_cap && (r_cap_idx == CH_B)) w_next = OUT;
      end
      default: begin
        if (out_ready) w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_color     <= '0;
      r_intensity <= '0;
      r_ambient   <= '0;
      r_issue_idx <= CH_R;
      r_cap_idx   <= CH_R;
      r_out_color <= '0;
    end else begin
      if ((r_state == IDLE) && in_valid) begin
        r_color     <= in_color;
        r_intensity <= in_intensity;
        r_ambient   <= in_ambient;
        r_issue_idx <= CH_R;
        r_cap_idx   <= CH_R;
      end
      if ((r_state == ISSUE) && (r_issue_idx != CH_B))
        r_issue_idx <= chan_idx_t'(r_issue_idx + 2'd1);
      if (w_cap) begin
        case (r_cap_idx)
          CH_R:    r_out_color[2*CH_W +: CH_W] <= w_cap_val;
          CH_G:    r_out_color[CH_W +: CH_W]   <= w_cap_val;
          default: r_out_color[0 +: CH_W]      <= w_cap_val;
        endcase
        if (r_cap_idx != CH_B) r_cap_idx <= chan_idx_t'(r_cap_idx + 2'd1);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign out_color = r_out_color;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rgb_shade_sequencer.sv
// tb/tb_rgb_shade_sequencer.sv - randomized scoreboard bench for the shade sequencer
module tb_rgb_shade_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_color = '0;
  logic [7:0]  in_intensity = '0;
  logic [7:0]  in_ambient = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_valid_a, busy_a;
  logic [23:0] out_color_a;
  logic        in_ready_n, out_valid_n, busy_n;
  logic [23:0] out_color_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = 0;

  logic [23:0] q_a[$];
  logic [23:0] q_n[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb_shade_sequencer #(.AMBIENT_EN(1'b1)) dut_amb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_color(in_color), .in_intensity(in_intensity), .in_ambient(in_ambient),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_color(out_color_a), .busy(busy_a)
  );

  rgb_shade_sequencer #(.AMBIENT_EN(1'b0)) dut_noamb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_color(in_color), .in_intensity(in_intensity), .in_ambient(in_ambient),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_color(out_color_n), .busy(busy_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] shade(input logic [23:0] c, input logic [7:0] i,
                                        input logic [7:0] amb, input bit use_amb);
    logic [23:0] r;
    for (int ch = 0; ch < 3; ch++) begin
      int v;
      v = (int'(c[ch*8 +: 8]) * int'(i)) / 256;
      if (use_amb) v = v + int'(amb);
      if (v > 255) v = 255;
      r[ch*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  // Stimulus side of the scoreboard: an accept happens on the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      q_n.delete();
    end else if (in_valid && in_ready_a) begin
      q_a.push_back(shade(in_color, in_intensity, in_ambient, 1'b1));
      q_n.push_back(shade(in_color, in_intensity, in_ambient, 1'b0));
      last_accept = cyc + 1;
    end
  end

  logic prev_va = 1'b0;
  logic prev_vn = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_a && !prev_va) check("latency_amb", 32'(cyc - last_accept), 32'd4);
      if (out_valid_n && !prev_vn) check("latency_noamb", 32'(cyc - last_accept), 32'd4);
      if (out_valid_a && out_ready) begin
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL out_amb_unexpected: got %h, expected no output", out_color_a);
        end else check("out_color_amb", 32'(out_color_a), 32'(q_a.pop_front()));
      end
      if (out_valid_n && out_ready) begin
        if (q_n.size() == 0) begin
          errors++;
          $display("FAIL out_noamb_unexpected: got %h, expected no output", out_color_n);
        end else check("out_color_noamb", 32'(out_color_n), 32'(q_n.pop_front()));
      end
    end
    prev_va = out_valid_a && !rst;
    prev_vn = out_valid_n && !rst;
  end

  task automatic wait_accept(output int edge_no);
    int n;
    edge_no = -1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (in_ready_a) break;
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout: got no accept, expected one within 100 cycles");
    end
    edge_no = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] c, input logic [7:0] i, input logic [7:0] amb,
                      input bit hold_valid, output int edge_no);
    in_color = c;
    in_intensity = i;
    in_ambient = amb;
    in_valid = 1'b1;
    wait_accept(edge_no);
    in_valid = hold_valid;
    in_color = 24'($urandom);
    in_intensity = 8'($urandom);
    in_ambient = 8'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 200 && (busy_a || q_a.size() != 0 || q_n.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: got busy=%0d pending=%0d, expected idle", busy_a, q_a.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int edges[8];
    logic [23:0] held;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_color", 32'(out_color_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(24'h402010, 8'h80, 8'h00, 1'b0, e);
    drain();
    send(24'hFF8000, 8'hFF, 8'h00, 1'b0, e);
    drain();
    send(24'hFF8000, 8'hFF, 8'h10, 1'b0, e);
    drain();

    // Backpressure with a second pixel waiting on in_valid.
    out_ready = 1'b0;
    send(24'($urandom), 8'($urandom), 8'($urandom), 1'b1, e);
    in_color = 24'h123456;
    in_intensity = 8'hC3;
    in_ambient = 8'h21;
    for (int n = 0; n < 20 && !out_valid_a; n++) @(negedge clk);
    if (!out_valid_a) begin
      errors++;
      $display("FAIL bp_no_output: got out_valid=0, expected 1");
    end
    @(negedge clk);
    held = out_color_a;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("bp_color_stable", 32'(out_color_a), 32'(held));
      check("bp_in_ready", 32'(in_ready_a), 32'd0);
      check("bp_out_valid", 32'(out_valid_a), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_idle", 32'(busy_a), 32'd0);
    check("bp_release_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_accept", 32'(busy_a), 32'd1);
    drain();

    // Reset during the B issue cycle, right after G went out.
    send(24'hA0B0C0, 8'hF0, 8'h05, 1'b0, e);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_color", 32'(out_color_a), 32'd0);
    @(negedge clk);
    check("midrst_no_capture", 32'(out_color_a), 32'd0);
    check("midrst_still_idle", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    send(24'h402010, 8'h80, 8'h00, 1'b0, e);
    drain();

    // Back-to-back random stream.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] iv;
      iv = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'($urandom);
      send(24'($urandom), iv, 8'($urandom), (k != 7), edges[k]);
    end
    for (int k = 1; k < 8; k++) check("stream_spacing", 32'(edges[k] - edges[k-1]), 32'd6);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
